mips_sim_ctrl: RTL and testbench

Reusable, parametrised run controller for CPU simulation benches. It replaces the hand-timed reset pulse with a counted CPU reset sequence, and detects program end by watching the PC. It enforces a cycle timeout and accumulates a write-trace signature over register-file and data-memory writes, so two CPU generations can be compared by a single value. It sits beside the CPU top in the bench and drives the CPU's reset.

---
 rtl/mips_sim_ctrl.sv | 106 ++++++++++
 tb/tb_mips_sim_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_sim_ctrl.sv
// Run controller for CPU simulation benches: sequences CPU reset, detects halt by a stalled PC,
// enforces a cycle timeout and folds register-file/data-memory writes into a trace signature.
module mips_sim_ctrl #(
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned STALL_LIMIT = 16,
    parameter int unsigned TIMEOUT     = 100000,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned PC_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  pc,
    input  logic             grf_we,
    input  logic [4:0]       grf_addr,
    input  logic [31:0]      grf_wdata,
    input  logic             dm_we,
    input  logic [31:0]      dm_addr,
    input  logic [31:0]      dm_wdata,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] event_count,
    output logic [31:0]      signature
);

    typedef enum logic [1:0] {StHold, StRun, StHalted, StTimeout} state_e;

    state_e           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] same_cnt;
    logic [PC_W-1:0]  pc_q;

    logic             g_ev;
    logic             d_ev;
    logic             pc_same;
    logic             halt;
    logic             tmo;
    logic [31:0]      sig_g;
    logic [31:0]      sig_next;
    logic [CNT_W-1:0] ev_inc;

    always_comb begin
        g_ev     = grf_we && (grf_addr != 5'd0);
        d_ev     = dm_we;
        // A same-cycle register write is folded in before the memory write.
        sig_g    = g_ev ? ({signature[30:0], signature[31]} ^ grf_wdata ^ {27'b0, grf_addr})
                        : signature;
        sig_next = d_ev ? ({sig_g[30:0], sig_g[31]} ^ dm_wdata ^ dm_addr) : sig_g;
        ev_inc   = CNT_W'(g_ev) + CNT_W'(d_ev);
        pc_same  = (pc == pc_q);
        halt     = pc_same && (same_cnt == CNT_W'(STALL_LIMIT - 1));
        tmo      = (cycle_count == CNT_W'(TIMEOUT - 1)) && !halt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StHold;
            hold_cnt    <= '0;
            same_cnt    <= '0;
            pc_q        <= '0;
            cpu_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
            cycle_count <= '0;
            event_count <= '0;
            signature   <= '0;
        end else begin
            case (state)
                StHold: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        state     <= StRun;
                        cpu_reset <= 1'b0;
                        running   <= 1'b1;
                        pc_q      <= pc;
                        same_cnt  <= '0;
                    end
                end
                StRun: begin
                    cycle_count <= cycle_count + 1'b1;
                    pc_q        <= pc;
                    same_cnt    <= pc_same ? same_cnt + 1'b1 : '0;
                    event_count <= event_count + ev_inc;
                    signature   <= sig_next;
                    // Halt takes priority when both end conditions land on one edge.
                    if (halt) begin
                        state   <= StHalted;
                        done    <= 1'b1;
                        running <= 1'b0;
                    end else if (tmo) begin
                        state     <= StTimeout;
                        timed_out <= 1'b1;
                        running   <= 1'b0;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_sim_ctrl.sv
// Directed bench for mips_sim_ctrl: expected outputs are queued per step and compared after the edge.
module tb_mips_sim_ctrl;

    localparam int unsigned RST   = 4;
    localparam int unsigned STALL = 4;
    localparam int unsigned TMO   = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        grf_we;
    logic [4:0]  grf_addr;
    logic [31:0] grf_wdata;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        cpu_reset;
    logic        running;
    logic        done;
    logic        timed_out;
    logic [31:0] cycle_count;
    logic [31:0] event_count;
    logic [31:0] signature;

    always #5 clk = ~clk;

    mips_sim_ctrl #(
        .RST_CYCLES (RST),
        .STALL_LIMIT(STALL),
        .TIMEOUT    (TMO),
        .CNT_W      (32),
        .PC_W       (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .grf_we     (grf_we),
        .grf_addr   (grf_addr),
        .grf_wdata  (grf_wdata),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .cpu_reset  (cpu_reset),
        .running    (running),
        .done       (done),
        .timed_out  (timed_out),
        .cycle_count(cycle_count),
        .event_count(event_count),
        .signature  (signature)
    );

    typedef struct {
        string       tag;
        logic        cr;
        logic        run;
        logic        dn;
        logic        to;
        logic [31:0] cc;
        logic [31:0] ec;
        logic [31:0] sig;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic        x_cr, x_run, x_dn, x_to;
    logic [31:0] x_cc, x_ec, x_sig;

    function automatic logic [31:0] rotl(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        exp_t e;
        e.tag = tag;
        e.cr  = x_cr;
        e.run = x_run;
        e.dn  = x_dn;
        e.to  = x_to;
        e.cc  = x_cc;
        e.ec  = x_ec;
        e.sig = x_sig;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, ".cpu_reset"}, 32'(cpu_reset), 32'(e.cr));
        check({e.tag, ".running"},   32'(running),   32'(e.run));
        check({e.tag, ".done"},      32'(done),      32'(e.dn));
        check({e.tag, ".timed_out"}, 32'(timed_out), 32'(e.to));
        check({e.tag, ".cycles"},    cycle_count,    e.cc);
        check({e.tag, ".events"},    event_count,    e.ec);
        check({e.tag, ".signature"}, signature,      e.sig);
    endtask

    task automatic rst_exp();
        x_cr  = 1'b1;
        x_run = 1'b0;
        x_dn  = 1'b0;
        x_to  = 1'b0;
        x_cc  = '0;
        x_ec  = '0;
        x_sig = '0;
    endtask

    task automatic idle();
        grf_we    = 1'b0;
        grf_addr  = '0;
        grf_wdata = '0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
    endtask

    // Releases reset and walks the HOLD window, expecting RUN on the RST-th edge.
    task automatic hold_seq(input string tag);
        reset = 1'b0;
        for (int i = 0; i < RST - 1; i++) tick({tag, ".hold"});
        x_cr  = 1'b0;
        x_run = 1'b1;
        tick({tag, ".hold_exit"});
    endtask

    initial begin
        reset = 1'b1;
        pc    = 32'h3000;
        idle();
        rst_exp();
        tick("rst0");
        tick("rst1");

        // Writes during HOLD must be ignored.
        grf_we = 1'b1; grf_addr = 5'd8; grf_wdata = 32'h1;
        dm_we  = 1'b1; dm_addr = 32'h4; dm_wdata = 32'h10;
        hold_seq("a");

        pc = 32'h3004; dm_we = 1'b0;
        x_cc = 1; x_ec = 1; x_sig = 32'h9;
        tick("g_write");
        pc = 32'h3008; grf_we = 1'b0; dm_we = 1'b1;
        x_cc = 2; x_ec = 2; x_sig = 32'h6;
        tick("d_write");
        dm_we = 1'b0; grf_we = 1'b1; grf_addr = 5'd0; grf_wdata = 32'hFFFF;
        x_cc = 3;
        tick("g_zero");
        grf_addr = 5'd5; grf_wdata = 32'hABCD; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h55;
        x_cc = 4; x_ec = 4;
        x_sig = rotl(rotl(x_sig) ^ 32'hABCD ^ 32'd5) ^ 32'h55 ^ 32'h20;
        tick("gd_pair");
        idle();
        x_cc = 5;
        tick("stall3");
        dm_we = 1'b1; dm_addr = 32'h8; dm_wdata = 32'h77;
        x_cc = 6; x_ec = 5; x_sig = rotl(x_sig) ^ 32'h77 ^ 32'h8;
        x_run = 1'b0; x_dn = 1'b1;
        tick("halt");
        pc = 32'h5000; grf_we = 1'b1; grf_addr = 5'd3; grf_wdata = 32'h1234;
        tick("frozen0");
        tick("frozen1");

        // Same-cycle pair from a clean signature, then reset mid-RUN.
        reset = 1'b1; idle(); pc = 32'h100; rst_exp();
        tick("rst2");
        hold_seq("c");
        pc = 32'h104;
        grf_we = 1'b1; grf_addr = 5'd8; grf_wdata = 32'h1;
        dm_we  = 1'b1; dm_addr = 32'h4; dm_wdata = 32'h10;
        x_cc = 1; x_ec = 2; x_sig = 32'h6;
        tick("gd_same");
        pc = 32'h108; dm_we = 1'b0; grf_addr = 5'd9; grf_wdata = 32'h42;
        x_cc = 2; x_ec = 3; x_sig = rotl(32'h6) ^ 32'h42 ^ 32'd9;
        tick("g_third");
        reset = 1'b1; idle(); rst_exp();
        tick("mid_reset");
        pc = 32'h200;
        hold_seq("d");

        // Free-running PC: timeout when the pre-increment count hits TMO-1.
        for (int k = 1; k < TMO; k++) begin
            pc = 32'h200 + 32'(4 * k);
            x_cc = 32'(k);
            tick("to_run");
        end
        pc = 32'h200 + 32'(4 * TMO);
        x_cc = TMO; x_run = 1'b0; x_to = 1'b1;
        tick("timeout");
        pc = 32'h300; dm_we = 1'b1;
        tick("to_frozen");

        // Halt lands on the same edge as the timeout.
        reset = 1'b1; idle(); pc = 32'h400; rst_exp();
        tick("rst3");
        hold_seq("e");
        for (int k = 1; k <= 6; k++) begin
            pc = 32'h400 + 32'(4 * k);
            x_cc = 32'(k);
            tick("co_run");
        end
        for (int k = 7; k < TMO; k++) begin
            x_cc = 32'(k);
            tick("co_stall");
        end
        x_cc = TMO; x_run = 1'b0; x_dn = 1'b1;
        tick("coincide");
        pc = 32'h999;
        tick("co_frozen");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
